// File: rtl/fx_accum_stream.sv
// Streaming signed fixed-point batch accumulator: sums num_samples products into a
// guarded accumulator, then presents a WIDTH-bit saturated result with a valid/ready hold.
module fx_accum_stream #(
    parameter int WIDTH = 32,
    parameter int QFRAC = 16,
    parameter int GUARD = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             sat_flag,
    output logic             drop_err,
    output logic             busy
);

    localparam int AW = WIDTH + GUARD;

    localparam logic [AW-1:0]    ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0]    ACC_MIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // The binary point is only carried through; it must still lie inside the word.
    if (QFRAC < 0 || QFRAC >= WIDTH) begin : g_qfrac_out_of_range
        $error("fx_accum_stream: QFRAC must lie in [0, WIDTH-1]");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state, state_next;
    logic [AW-1:0]    acc, acc_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] target, target_next;
    logic             sat_int, sat_int_next;
    logic [WIDTH-1:0] sum_next;
    logic             sat_flag_next;
    logic             drop_next;

    logic [AW:0]      add_wide;
    logic             add_ovf;
    logic [AW-1:0]    acc_sat;
    logic             out_fits;
    logic [WIDTH-1:0] out_val;

    // One extra bit on the add exposes overflow as a disagreement of the top two bits.
    assign add_wide = {acc[AW-1], acc} + {{(GUARD + 1){data_in[WIDTH-1]}}, data_in};
    assign add_ovf  = add_wide[AW] ^ add_wide[AW-1];
    assign acc_sat  = add_ovf ? (add_wide[AW] ? ACC_MIN : ACC_MAX) : add_wide[AW-1:0];
    assign out_fits = (acc_sat[AW-1:WIDTH-1] == '0) || (acc_sat[AW-1:WIDTH-1] == '1);
    assign out_val  = out_fits ? acc_sat[WIDTH-1:0] : (acc_sat[AW-1] ? OUT_MIN : OUT_MAX);

    assign sum_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    always_comb begin
        state_next    = state;
        acc_next      = acc;
        cnt_next      = cnt;
        target_next   = target;
        sat_int_next  = sat_int;
        sum_next      = sum_out;
        sat_flag_next = sat_flag;
        drop_next     = drop_err;
        case (state)
            IDLE: begin
                if (valid_in) drop_next = 1'b1;
                if (start) begin
                    if (num_samples != '0) begin
                        state_next   = ACCUM;
                        acc_next     = '0;
                        cnt_next     = '0;
                        sat_int_next = 1'b0;
                        target_next  = num_samples;
                        drop_next    = valid_in;
                    end else begin
                        state_next    = HOLD;
                        sum_next      = '0;
                        sat_flag_next = 1'b0;
                    end
                end
            end
            ACCUM: begin
                if (valid_in && (cnt < target)) begin
                    acc_next     = acc_sat;
                    cnt_next     = cnt + CNT_ONE;
                    sat_int_next = sat_int | add_ovf;
                    // The result is latched on the same edge that takes the final sample.
                    if ((cnt + CNT_ONE) == target) begin
                        state_next    = HOLD;
                        sum_next      = out_val;
                        sat_flag_next = sat_int | add_ovf | ~out_fits;
                    end
                end
            end
            HOLD: begin
                if (valid_in) drop_next = 1'b1;
                if (sum_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            target   <= '0;
            sat_int  <= 1'b0;
            sum_out  <= '0;
            sat_flag <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            cnt      <= cnt_next;
            target   <= target_next;
            sat_int  <= sat_int_next;
            sum_out  <= sum_next;
            sat_flag <= sat_flag_next;
            drop_err <= drop_next;
        end
    end

endmodule

// File: doc/fx_accum_stream.md
FX_ACCUM_STREAM -- requirements
Module: fx_accum_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: width of signed fixed-point samples and result.
REQ-002 The block SHALL have parameter QFRAC, default 16: fractional bits, which SHALL be carried unchanged with no rescaling.
REQ-003 The block SHALL have parameter GUARD, default 8: extra accumulator MSBs, giving an accumulator width of WIDTH+GUARD.
REQ-004 The block SHALL have parameter CNT_W, default 16: width of the sample counter.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  single-cycle request to begin a batch; accepted only in IDLE.
REQ-008 num_samples  input  CNT_W  unsigned products expected in the batch; sampled when start is accepted.
REQ-009 valid_in  input  1  product-stream valid from the upstream multiplier; there is no backpressure.
REQ-010 data_in  input  WIDTH  signed product, same Q format as the result.
REQ-011 sum_valid  output  1  result available.
REQ-012 sum_ready  input  1  consumer accepts the result.
REQ-013 sum_out  output  WIDTH  signed saturated batch sum.
REQ-014 sat_flag  output  1  the batch clamped at least once; qualified by sum_valid.
REQ-015 drop_err  output  1  sticky: valid_in was seen outside ACCUM.
REQ-016 busy  output  1  high in ACCUM or HOLD.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-018 IDLE transitions SHALL be:
- start=1 and num_samples>0: go to ACCUM; acc=0, cnt=0, internal sat=0, drop_err cleared.
- start=1 and num_samples=0: go to HOLD next cycle; sum_out=0, sat_flag=0.
REQ-019 In ACCUM, every cycle with valid_in=1 SHALL add sign-extended data_in to acc and increment cnt.
REQ-020 The ACCUM add SHALL saturate to the (WIDTH+GUARD)-bit signed range, setting internal sat when it clamps.
REQ-021 When the accepted sample makes cnt equal num_samples, the next state SHALL be HOLD.
REQ-022 Latency: sum_valid SHALL rise exactly one cycle after the clock edge that accepts the last sample.
REQ-023 On entry to HOLD, sum_out SHALL be acc saturated to the WIDTH-bit signed range: max 2^(WIDTH-1)-1, min -2^(WIDTH-1).
REQ-024 sat_flag SHALL equal internal sat OR the output clamp.
REQ-025 In HOLD, sum_valid=1 and sum_out/sat_flag SHALL stay stable until sum_valid and sum_ready are both high.
REQ-026 HOLD SHALL go to IDLE on the handshake cycle; sum_valid SHALL be 0 the following cycle.
REQ-027 start SHALL be ignored in ACCUM and HOLD, with no state change and no re-sampling of num_samples.
REQ-028 valid_in=1 in IDLE or HOLD SHALL be discarded, with acc and cnt unchanged, and SHALL set drop_err.
REQ-029 Simultaneous start and valid_in in IDLE: the sample SHALL be discarded and SHALL set drop_err in the same cycle as the clear; drop_err reads 1 in ACCUM.
REQ-030 The counter SHALL never wrap; cnt increments only while cnt<num_samples.
REQ-031 busy SHALL be combinational from state (ACCUM or HOLD).

Reset
REQ-032 When rst=1 at a clock edge, the block SHALL go to IDLE and clear acc and cnt.
REQ-033 On that reset, sum_valid, sum_out, sat_flag, drop_err and busy SHALL all be 0.
REQ-034 Reset SHALL take priority over all inputs.
REQ-035 Reset mid-ACCUM or mid-HOLD SHALL abandon the batch with no result emitted.
REQ-036 Outputs SHALL be 0 in the first cycle after rst deasserts.

Verification
REQ-037 Basic sum (Q16.16): start, num_samples=3; data 0x00018000, 0x00008000, 0xFFFF0000 on consecutive cycles with sum_ready=1 -> one cycle after the third sample, sum_valid=1, sum_out=0x00010000, sat_flag=0; IDLE next cycle.
REQ-038 Gapped stream plus backpressure: num_samples=2, samples 0x00020000 and 0x00030000 with 4 idle cycles between, sum_ready=0 for 5 cycles -> sum_out=0x00050000 held stable with sum_valid=1 until sum_ready=1, then sum_valid=0.
REQ-039 Output saturation: num_samples=2, samples 0x7FFFFFFF and 0x7FFFFFFF -> sum_out=0x7FFFFFFF, sat_flag=1; negative case 0x80000000 twice -> sum_out=0x80000000, sat_flag=1.
REQ-040 Zero-length batch: start with num_samples=0 -> sum_valid=1 the cycle after start, sum_out=0, sat_flag=0.
REQ-041 Stray input and ignored start: valid_in=1 in IDLE -> drop_err=1, later sum unaffected; start asserted mid-ACCUM -> ignored, batch completes with the original count.
REQ-042 Reset mid-batch: rst=1 after 1 of 4 samples -> next cycle busy=0 and sum_valid=0; a new batch num_samples=1 with sample 0x00010000 -> sum_out=0x00010000.
